// File: rtl/load_use_hazard_unit.sv
// Pipeline hazard controller for an LC-3b style five-stage core: resolves
// data-memory waits, load-use dependencies and instruction-fetch waits.
package lc3b_pkg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [2:0] lc3b_reg;

endpackage

module load_use_hazard_unit
    import lc3b_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  lc3b_opcode  id_opcode,
    input  lc3b_reg     id_sr1,
    input  lc3b_reg     id_sr2,
    input  lc3b_reg     id_st_src,
    input  logic        id_imm_mode,
    input  logic        ex_valid,
    input  lc3b_opcode  ex_opcode,
    input  logic        ex_regwrite,
    input  lc3b_reg     ex_destreg,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        dmem_resp,
    input  logic        imem_read,
    input  logic        imem_resp,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        bubble_id,
    output logic        bubble_ex,
    output logic [15:0] stall_cycles,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_LU_BUBBLE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_cycles;
    logic        r_mem_timeout;

    logic w_use_sr1;
    logic w_use_sr2;
    logic w_use_st;
    logic w_ex_is_load;
    logic w_dmem_wait;
    logic w_imem_wait;
    logic w_load_use;
    logic w_any_stall;

    // Source-operand usage decoded from the ID opcode.
    assign w_use_sr1 = id_opcode inside {op_add, op_and, op_not, op_ldr, op_ldb, op_ldi,
                                         op_str, op_stb, op_sti, op_jmp, op_shf};
    assign w_use_sr2 = (id_opcode inside {op_add, op_and}) && !id_imm_mode;
    assign w_use_st  = id_opcode inside {op_str, op_stb, op_sti};

    assign w_ex_is_load = ex_opcode inside {op_ldr, op_ldb, op_ldi};
    assign w_dmem_wait  = (dmem_read || dmem_write) && !dmem_resp;
    assign w_imem_wait  = imem_read && !imem_resp;

    assign w_load_use = id_valid && ex_valid && ex_regwrite && w_ex_is_load &&
                        ((w_use_sr1 && (ex_destreg == id_sr1)) ||
                         (w_use_sr2 && (ex_destreg == id_sr2)) ||
                         (w_use_st  && (ex_destreg == id_st_src)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_dmem_wait) begin
                    w_state_next = ST_DMEM_WAIT;
                end else if (w_load_use) begin
                    w_state_next = ST_LU_BUBBLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DMEM_WAIT: begin
                w_state_next = w_dmem_wait ? ST_DMEM_WAIT : ST_RUN;
            end
            ST_LU_BUBBLE: begin
                // Detection is ignored here so one load-use yields one bubble.
                w_state_next = w_dmem_wait ? ST_DMEM_WAIT : ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        bubble_id = 1'b0;
        bubble_ex = 1'b0;
        if (w_dmem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if ((r_state == ST_RUN) && w_load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (w_imem_wait) begin
            stall_if  = 1'b1;
            bubble_id = 1'b1;
        end
    end

    assign w_any_stall = stall_if || stall_id || stall_ex || stall_mem;

    // Data-wait watchdog: the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (!w_dmem_wait) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_dmem_wait && (r_wait_cnt == 8'hFF)) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (w_any_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit: stall/bubble priority, FSM
// sequencing, stall counter and data-wait timeout.
module tb_load_use_hazard_unit;
    import lc3b_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    lc3b_opcode  id_opcode;
    lc3b_reg     id_sr1;
    lc3b_reg     id_sr2;
    lc3b_reg     id_st_src;
    logic        id_imm_mode;
    logic        ex_valid;
    lc3b_opcode  ex_opcode;
    logic        ex_regwrite;
    lc3b_reg     ex_destreg;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_resp;
    logic        imem_read;
    logic        imem_resp;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        stall_mem;
    logic        bubble_id;
    logic        bubble_ex;
    logic [15:0] stall_cycles;
    logic        mem_timeout;

    logic [5:0]  outs;
    int          checks;
    int          failures;

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_FULL = 6'b111100;
    localparam logic [5:0] O_LU   = 6'b110001;
    localparam logic [5:0] O_IMEM = 6'b100010;

    typedef struct packed {
        logic       idv;
        logic       exv;
        logic       regw;
        lc3b_opcode exop;
        lc3b_reg    dest;
        lc3b_opcode idop;
        lc3b_reg    sr1;
        lc3b_reg    sr2;
        lc3b_reg    st;
        logic       imm;
        logic       exp_lu;
    } lu_vec_t;

    assign outs = {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex};

    load_use_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_sr1       (id_sr1),
        .id_sr2       (id_sr2),
        .id_st_src    (id_st_src),
        .id_imm_mode  (id_imm_mode),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_regwrite  (ex_regwrite),
        .ex_destreg   (ex_destreg),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_resp    (dmem_resp),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .bubble_id    (bubble_id),
        .bubble_ex    (bubble_ex),
        .stall_cycles (stall_cycles),
        .mem_timeout  (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        id_valid    = 1'b0;
        id_opcode   = op_br;
        id_sr1      = 3'd0;
        id_sr2      = 3'd0;
        id_st_src   = 3'd0;
        id_imm_mode = 1'b0;
        ex_valid    = 1'b0;
        ex_opcode   = op_br;
        ex_regwrite = 1'b0;
        ex_destreg  = 3'd0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        dmem_resp   = 1'b0;
        imem_read   = 1'b0;
        imem_resp   = 1'b0;
    endtask

    // EX: ldr R3 ; ID: add R1, R3, R2
    task automatic drive_lu();
        id_valid    = 1'b1;
        id_opcode   = op_add;
        id_sr1      = 3'd3;
        id_sr2      = 3'd2;
        id_st_src   = 3'd1;
        id_imm_mode = 1'b0;
        ex_valid    = 1'b1;
        ex_opcode   = op_ldr;
        ex_regwrite = 1'b1;
        ex_destreg  = 3'd3;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        dmem_read = 1'b1;
        #1;
        checks++;
        if (outs !== O_FULL) begin
            failures++;
            $display("FAIL reset_comb_full: got %b expected %b", outs, O_FULL);
        end
        @(negedge clk);
        checks++;
        if (stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
        end
        dmem_read = 1'b0;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            failures++;
            $display("FAIL reset_idle_outs: got %b expected %b", outs, O_NONE);
        end
        $display("test_reset done: stall_cycles=%0d mem_timeout=%b", stall_cycles, mem_timeout);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        apply_reset();
        drive_lu();
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL lu_bubble: got %b expected %b", outs, O_LU);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_NONE) begin
            failures++;
            $display("FAIL lu_single_bubble: got %b expected %b", outs, O_NONE);
        end
        checks++;
        if (stall_cycles !== 16'd1) begin
            failures++;
            $display("FAIL lu_stall_cycles: got %0d expected 1", stall_cycles);
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_cycles !== 16'd1) begin
            failures++;
            $display("FAIL lu_stall_cycles_hold: got %0d expected 1", stall_cycles);
        end
        $display("test_load_use done: stall_cycles=%0d", stall_cycles);
    endtask

    task automatic test_lu_matrix();
        lu_vec_t vecs[13];
        vecs[0]  = '{1'b1, 1'b1, 1'b1, op_ldr, 3'd3, op_add, 3'd3, 3'd2, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, op_ldr, 3'd3, op_and, 3'd2, 3'd3, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, op_ldr, 3'd3, op_add, 3'd2, 3'd3, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, op_add, 3'd3, op_add, 3'd3, 3'd2, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, op_ldb, 3'd3, op_str, 3'd1, 3'd0, 3'd3, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, op_ldi, 3'd3, op_br,  3'd3, 3'd3, 3'd3, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, op_ldi, 3'd5, op_jmp, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, op_ldr, 3'd3, op_add, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, op_ldr, 3'd3, op_add, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, op_ldr, 3'd3, op_add, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, op_ldr, 3'd3, op_not, 3'd5, 3'd3, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, op_ldr, 3'd7, op_shf, 3'd7, 3'd0, 3'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, op_ldb, 3'd4, op_sti, 3'd0, 3'd4, 3'd4, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            id_valid    = vecs[i].idv;
            ex_valid    = vecs[i].exv;
            ex_regwrite = vecs[i].regw;
            ex_opcode   = vecs[i].exop;
            ex_destreg  = vecs[i].dest;
            id_opcode   = vecs[i].idop;
            id_sr1      = vecs[i].sr1;
            id_sr2      = vecs[i].sr2;
            id_st_src   = vecs[i].st;
            id_imm_mode = vecs[i].imm;
            #1;
            checks++;
            if (outs !== (vecs[i].exp_lu ? O_LU : O_NONE)) begin
                failures++;
                $display("FAIL lu_vec%0d: got %b expected %b", i, outs,
                         (vecs[i].exp_lu ? O_LU : O_NONE));
            end
            $display("lu_vec%0d ex=%s id=%s outs=%b", i, vecs[i].exop.name(),
                     vecs[i].idop.name(), outs);
            @(negedge clk);
            set_idle();
            @(negedge clk);
        end
    endtask

    task automatic test_imem();
        apply_reset();
        imem_read = 1'b1;
        #1;
        checks++;
        if (outs !== O_IMEM) begin
            failures++;
            $display("FAIL imem_wait: got %b expected %b", outs, O_IMEM);
        end
        @(negedge clk);
        drive_lu();
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL imem_vs_lu: got %b expected %b", outs, O_LU);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_IMEM) begin
            failures++;
            $display("FAIL imem_in_lu_bubble: got %b expected %b", outs, O_IMEM);
        end
        @(negedge clk);
        set_idle();
        imem_read = 1'b1;
        imem_resp = 1'b1;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            failures++;
            $display("FAIL imem_resp: got %b expected %b", outs, O_NONE);
        end
        $display("test_imem done: outs=%b", outs);
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_dmem_wait();
        apply_reset();
        dmem_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== O_FULL) begin
                failures++;
                $display("FAIL dmem_stall%0d: got %b expected %b", i, outs, O_FULL);
            end
            @(negedge clk);
        end
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            failures++;
            $display("FAIL dmem_resp_drop: got %b expected %b", outs, O_NONE);
        end
        @(negedge clk);
        set_idle();
        checks++;
        if (stall_cycles !== 16'd4) begin
            failures++;
            $display("FAIL dmem_stall_cycles: got %0d expected 4", stall_cycles);
        end
        drive_lu();
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL dmem_back_to_run: got %b expected %b", outs, O_LU);
        end
        $display("test_dmem_wait done: stall_cycles=%0d", stall_cycles);
        @(negedge clk);
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_lu_with_dmem();
        apply_reset();
        drive_lu();
        dmem_read = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== O_FULL) begin
                failures++;
                $display("FAIL lu_dmem_full%0d: got %b expected %b", i, outs, O_FULL);
            end
            @(negedge clk);
        end
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            failures++;
            $display("FAIL lu_dmem_resp: got %b expected %b", outs, O_NONE);
        end
        @(negedge clk);
        dmem_read = 1'b0;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL lu_after_resp: got %b expected %b", outs, O_LU);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_NONE) begin
            failures++;
            $display("FAIL lu_after_resp_once: got %b expected %b", outs, O_NONE);
        end
        $display("test_lu_with_dmem done: stall_cycles=%0d", stall_cycles);
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        dmem_read = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_FULL) begin
            failures++;
            $display("FAIL reset_mid_comb: got %b expected %b", outs, O_FULL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dmem_read = 1'b0;
        drive_lu();
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL reset_mid_abandon: got %b expected %b", outs, O_LU);
        end
        $display("test_reset_mid_wait done: outs=%b", outs);
        @(negedge clk);
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        apply_reset();
        dmem_read = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 255) begin
                checks++;
                if (mem_timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_early: got %b expected 0", mem_timeout);
                end
            end
            if (i == 256) begin
                checks++;
                if (mem_timeout !== 1'b1) begin
                    failures++;
                    $display("FAIL timeout_rise: got %b expected 1", mem_timeout);
                end
            end
        end
        checks++;
        if (outs !== O_FULL) begin
            failures++;
            $display("FAIL timeout_stalls: got %b expected %b", outs, O_FULL);
        end
        checks++;
        if (stall_cycles !== 16'd300) begin
            failures++;
            $display("FAIL timeout_stall_cycles: got %0d expected 300", stall_cycles);
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        set_idle();
        checks++;
        if (mem_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %b expected 1", mem_timeout);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got %b expected 0", mem_timeout);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL timeout_cnt_clear: got %0d expected 0", stall_cycles);
        end
        drive_lu();
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL timeout_state_run: got %b expected %b", outs, O_LU);
        end
        $display("test_timeout done: mem_timeout=%b stall_cycles=%0d", mem_timeout, stall_cycles);
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_lu_matrix();
        test_imem();
        test_dmem_wait();
        test_lu_with_dmem();
        test_reset_mid_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_use_hazard_unit.md
LOAD_USE_HAZARD_UNIT -- requirements
Module: load_use_hazard_unit

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-low reset: clk rising-edge; rst_n sampled only on clk rising edge, 0 = reset.
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  clock
  rst_n  in  1  sync active-low reset
  id_valid  in  1  ID holds a real instruction
  id_opcode  in  lc3b_opcode  ID opcode
  id_sr1 / id_sr2 / id_st_src  in  lc3b_reg  ID source fields (st_src = IR[11:9])
  id_imm_mode  in  1  IR[5] of ID instruction
  ex_valid  in  1  EX holds a real instruction
  ex_opcode  in  lc3b_opcode  EX opcode
  ex_regwrite  in  1  EX writes the register file
  ex_destreg  in  lc3b_reg  EX destination
  dmem_read / dmem_write  in  1  MEM-stage data request
  dmem_resp  in  1  data memory done
  imem_read / imem_resp  in  1  fetch request / done
  stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage's pipeline register
  bubble_id  out  1  load NOP into IF/ID
  bubble_ex  out  1  load NOP into ID/EX
  stall_cycles  out  16  saturating count of stall cycles
  mem_timeout  out  1  sticky: data wait exceeded limit

Function
REQ-003 The unit SHALL hold state in {RUN, DMEM_WAIT, LU_BUBBLE}; outputs are combinational in state and inputs.
REQ-004 The unit SHALL define use_sr1 for op_add, op_and, op_not, op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti, op_jmp, op_shf.
REQ-005 The unit SHALL define use_sr2 = (op_add or op_and) and id_imm_mode = 0.
REQ-006 The unit SHALL define use_st for op_str, op_stb, op_sti.
REQ-007 The unit SHALL define dmem_wait = (dmem_read or dmem_write) and not dmem_resp.
REQ-008 The unit SHALL define load_use = id_valid, ex_valid and ex_regwrite all 1, ex_opcode in {op_ldr, op_ldb, op_ldi}, and ex_destreg equal to a used source (id_sr1 with use_sr1, id_sr2 with use_sr2, or id_st_src with use_st).
REQ-009 Priority 1: if dmem_wait (any state), the unit SHALL assert all four stall_* = 1, bubble_id = 0 and bubble_ex = 0.
REQ-010 Priority 2: if state = RUN and load_use, the unit SHALL assert stall_if = 1, stall_id = 1 and bubble_ex = 1, with all other outputs 0.
REQ-011 Priority 3: if imem_read and not imem_resp, the unit SHALL assert stall_if = 1 and bubble_id = 1, with all other outputs 0.
REQ-012 Otherwise the unit SHALL hold all stall and bubble outputs at 0.
REQ-013 Transitions from RUN: dmem_wait -> DMEM_WAIT; else load_use -> LU_BUBBLE; else RUN.
REQ-014 Transitions from DMEM_WAIT: stay while dmem_wait; on dmem_resp = 1 -> RUN. Stalls drop in the same cycle resp is seen.
REQ-015 Transitions from LU_BUBBLE: dmem_wait -> DMEM_WAIT, else -> RUN. Load-use detection is suppressed in LU_BUBBLE, so there is exactly one bubble per load-use.
REQ-016 The unit SHALL keep an 8-bit wait_cnt: cleared when not dmem_wait, incremented each dmem_wait cycle, saturating at 255.
REQ-017 If dmem_wait while wait_cnt = 255, the unit SHALL set mem_timeout next edge; it stays 1 until reset and does not alter the stalls.
REQ-018 The unit SHALL increment stall_cycles by 1 each cycle any stall_* output is 1, saturating at 16'hFFFF.
REQ-019 The unit SHALL treat id_valid = 0 or ex_valid = 0 as no load_use, regardless of register fields.

Reset
REQ-020 While rst_n = 0 at an edge, the unit SHALL set state = RUN, wait_cnt = 0, stall_cycles = 0 and mem_timeout = 0.
REQ-021 Combinational outputs still follow REQ-009..012 during reset.
REQ-022 Reset asserted during DMEM_WAIT or LU_BUBBLE SHALL abandon that state with no residual bubble.

Verification
REQ-023 EX ldr R3, ID add R1,R3,R2 (imm_mode = 0) -> one cycle stall_if = stall_id = bubble_ex = 1; next cycle (LU_BUBBLE) all 0; stall_cycles = 1.
REQ-024 EX ldr R3, ID add R1,R2,#3 with sr2 field = R3, imm_mode = 1 -> no stall; EX add (not a load) with matching dest -> no stall.
REQ-025 dmem_read = 1, dmem_resp low for 4 cycles then high -> all stall_* = 1 for exactly 4 cycles, 0 on the resp cycle, state back to RUN; stall_cycles = 4.
REQ-026 Load-use and dmem_wait in the same cycle -> only full stall (bubble_ex = 0); after resp, the load-use bubble is issued once if the condition persists.
REQ-027 dmem_wait held 300 cycles -> mem_timeout rises after the 256th wait cycle and stays 1 after resp; rst_n = 0 for one edge clears it, state = RUN, stall_cycles = 0.
